iir_tap_sequencer: RTL and testbench
====================================

# iir_tap_sequencer

Circular sample-history buffer for the IIR filter datapath. It accepts one input sample per handshake and stores it as the newest history entry x[n]. It then streams the history x[n], x[n-1], …, x[n-TAPS+1] out one tap per handshake to the serial multiply-accumulate stage. It is the read side of the z^-1 delay chain: the delay registers write the history, and this block reads it back in tap order.

## Interface
- DATA_W, 32, sample width in bits (two's-complement; passed through unmodified).
- TAPS, 4, history depth and number of taps streamed per sample; legal range 2..16.
- ADDR_W, 4, tap index / buffer address width; must satisfy 2^ADDR_W >= TAPS.

- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  new sample present on in_data.
- in_data  input  DATA_W  input sample x[n].
- in_ready  output  1  block can accept a sample.
- out_valid  output  1  out_data/out_tap/out_last valid.
- out_ready  input  1  downstream MAC accepts the current tap.
- out_data  output  DATA_W  history sample x[n-out_tap].
- out_tap  output  ADDR_W  tap index k, 0..TAPS-1.
- out_last  output  1  high with the tap k = TAPS-1.

## Operation
- Storage: TAPS x DATA_W register array, write pointer wr_ptr (0..TAPS-1), fill counter fill (0..TAPS, saturating), tap counter k.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. When in_valid=1:
    - write in_data to mem[wr_ptr];
    - latch newest=wr_ptr;
    - advance wr_ptr by 1 modulo TAPS (wrap from TAPS-1 to 0);
    - fill = min(fill+1, TAPS);
    - k=0;
    - go to STREAM.
  - STREAM: in_ready=0, out_valid=1.
    - out_data = mem[(newest - k) mod TAPS] when k < fill, else 0. Never-written history reads as zero.
    - out_tap = k; out_last = (k == TAPS-1).
    - On out_ready=1: if out_last, go to IDLE; else k = k+1.
    - With out_ready=0, all out_* are held stable.
- in_data is ignored outside IDLE. in_valid may stay high without side effects.
- Reset (any time, including mid-STREAM) has these effects:
  - state=IDLE, wr_ptr=0, fill=0, k=0, newest=0;
  - in_ready=1, out_valid=0, out_data=0, out_tap=0, out_last=0;
  - array contents are don't-care, because they are masked by fill=0;
  - any partial stream is abandoned, and no further taps of it are emitted.
- Arithmetic: the pointer subtraction wraps modulo TAPS; it is not a power-of-two mask, because TAPS need not be a power of two. There is no arithmetic on data.

## Timing
- A sample is accepted on edge E (in_valid & in_ready). Tap 0 is presented on the cycle after E (out_valid high from E+1).
- Each tap is transferred on an edge where out_valid & out_ready are both high. The next tap appears on the following cycle (one tap per cycle at out_ready=1).
- The last tap is accepted on edge L. After L: in_ready=1 and out_valid=0.
- Minimum period is TAPS+1 cycles per sample. There is no input/output overlap.
- Combinationally, outputs depend only on registered state, not on out_ready or in_valid.

## Test plan
- **Reset defaults:** assert rst asynchronously mid-cycle → in_ready=1, out_valid=0, out_data=0, out_tap=0, out_last=0 immediately, without waiting for a clock.
- **First sample, zero history:** TAPS=4, push 0x00000011 → taps k=0..3 give 0x11, 0, 0, 0; out_last only on k=3; out_valid first high 1 cycle after acceptance.
- **Wrap-around:** push 1, 2, 3, 4, 5, 6 → the stream after 6 is 6, 5, 4, 3; the stream after 5 is 5, 4, 3, 2; fill saturates at 4.
- **Backpressure:** hold out_ready=0 for 3 cycles on k=1 → out_data/out_tap remain unchanged; in_ready stays 0; in_valid pulses with 0xDEAD are ignored, and 0xDEAD never appears.
- **Reset mid-stream:** push 7, 8, then assert rst during k=2 of sample 8 → out_valid drops; the next push 9 streams 9, 0, 0, 0.
- **Non-power-of-two depth:** TAPS=3, push 1..4 → the stream after 4 is 4, 3, 2; out_last on k=2.

Source files
------------

// File: rtl/iir_tap_sequencer.sv
// Circular sample-history buffer: stores one sample per input handshake and
// streams the TAPS most recent samples, newest first, one tap per output handshake.
module iir_tap_sequencer #(
    parameter int DATA_W = 32,
    parameter int TAPS   = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_tap,
    output logic              out_last
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(TAPS - 1);
    localparam logic [ADDR_W:0]   TAPS_F  = (ADDR_W + 1)'(TAPS);
    localparam logic [ADDR_W:0]   ONE_F   = (ADDR_W + 1)'(1);

    // (a - b) mod TAPS for a, b in 0..TAPS-1; TAPS need not be a power of two
    function automatic logic [ADDR_W-1:0] wrap_sub(input logic [ADDR_W-1:0] a,
                                                   input logic [ADDR_W-1:0] b);
        logic [ADDR_W:0] d;
        if (a >= b) begin
            d = {1'b0, a} - {1'b0, b};
        end else begin
            d = {1'b0, a} + TAPS_F - {1'b0, b};
        end
        return d[ADDR_W-1:0];
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;
    logic [DATA_W-1:0]   mem_r [1 << ADDR_W];
    logic [ADDR_W-1:0]   wr_ptr_r;
    logic [ADDR_W-1:0]   newest_r;
    logic [ADDR_W:0]     fill_r;
    logic [ADDR_W-1:0]   k_r;
    logic [DATA_W-1:0]   out_data_r;
    logic                out_last_r;
    logic                out_valid_r;
    logic                in_ready_r;

    logic                accept_s;
    logic                xfer_s;
    logic [ADDR_W-1:0]   next_k_s;
    logic [ADDR_W-1:0]   rd_idx_s;
    logic [DATA_W-1:0]   rd_data_s;

    // Handshakes, next-tap lookup and next-state decode
    always_comb begin
        accept_s    = in_valid & in_ready_r;
        xfer_s      = out_valid_r & out_ready;
        next_k_s    = k_r + ONE_A;
        rd_idx_s    = wrap_sub(newest_r, next_k_s);
        rd_data_s   = {DATA_W{1'b0}};
        state_nxt_s = state_r;
        // History beyond the fill level has never been written and reads as zero
        if ({1'b0, next_k_s} < fill_r) begin
            rd_data_s = mem_r[rd_idx_s];
        end else begin
            rd_data_s = {DATA_W{1'b0}};
        end
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = STREAM;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            STREAM: begin
                if (xfer_s && out_last_r) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = STREAM;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Sample storage; contents are masked by fill after reset
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // State, pointers and registered output stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            wr_ptr_r    <= {ADDR_W{1'b0}};
            newest_r    <= {ADDR_W{1'b0}};
            fill_r      <= {(ADDR_W + 1){1'b0}};
            k_r         <= {ADDR_W{1'b0}};
            out_data_r  <= {DATA_W{1'b0}};
            out_last_r  <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        newest_r    <= wr_ptr_r;
                        wr_ptr_r    <= (wr_ptr_r == LAST_A) ? {ADDR_W{1'b0}} : wr_ptr_r + ONE_A;
                        fill_r      <= (fill_r == TAPS_F) ? fill_r : fill_r + ONE_F;
                        k_r         <= {ADDR_W{1'b0}};
                        // Tap 0 is always the sample just written
                        out_data_r  <= in_data;
                        out_last_r  <= 1'b0;
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b0;
                    end
                end
                STREAM: begin
                    if (xfer_s) begin
                        if (out_last_r) begin
                            k_r         <= {ADDR_W{1'b0}};
                            out_data_r  <= {DATA_W{1'b0}};
                            out_last_r  <= 1'b0;
                            out_valid_r <= 1'b0;
                            in_ready_r  <= 1'b1;
                        end else begin
                            k_r        <= next_k_s;
                            out_data_r <= rd_data_s;
                            out_last_r <= (next_k_s == LAST_A);
                        end
                    end
                end
                default: begin
                    k_r         <= {ADDR_W{1'b0}};
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_tap   = k_r;
    assign out_last  = out_last_r;

endmodule

// File: tb/tb_iir_tap_sequencer.sv
// Scoreboard bench: a history-queue model predicts each tap stream; negedge
// monitors compare the two DUT instances (TAPS=4 and TAPS=3) against it.
module tb_iir_tap_sequencer;

    localparam int TA = 4;
    localparam int TB = 3;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  t;
        logic        l;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid_a = 1'b0, in_ready_a, out_valid_a, out_ready_a = 1'b0, out_last_a;
    logic [31:0] in_data_a = 32'h0, out_data_a;
    logic [3:0]  out_tap_a;
    logic        in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b0, out_last_b;
    logic [31:0] in_data_b = 32'h0, out_data_b;
    logic [3:0]  out_tap_b;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] hist_a[$];
    logic [31:0] hist_b[$];
    exp_t        exp_a[$];
    exp_t        exp_b[$];

    always #5 clk = ~clk;

    iir_tap_sequencer #(.DATA_W(32), .TAPS(TA), .ADDR_W(4)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a), .in_data(in_data_a), .in_ready(in_ready_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_data(out_data_a), .out_tap(out_tap_a), .out_last(out_last_a)
    );

    iir_tap_sequencer #(.DATA_W(32), .TAPS(TB), .ADDR_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_data(out_data_b), .out_tap(out_tap_b), .out_last(out_last_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the stream after a sample is the newest TAPS samples, newest first, zero-padded
    task automatic model_accept(input int sel, input logic [31:0] x);
        exp_t e;
        if (sel == 0) begin
            hist_a.push_front(x);
            if (hist_a.size() > TA) void'(hist_a.pop_back());
            for (int k = 0; k < TA; k++) begin
                e.d = (k < hist_a.size()) ? hist_a[k] : 32'h0;
                e.t = 4'(k);
                e.l = (k == TA - 1);
                exp_a.push_back(e);
            end
        end else begin
            hist_b.push_front(x);
            if (hist_b.size() > TB) void'(hist_b.pop_back());
            for (int k = 0; k < TB; k++) begin
                e.d = (k < hist_b.size()) ? hist_b[k] : 32'h0;
                e.t = 4'(k);
                e.l = (k == TB - 1);
                exp_b.push_back(e);
            end
        end
    endtask

    // Monitor for the TAPS=4 instance
    always @(negedge clk) begin
        if (!rst) begin
            check("a_out_valid", {31'h0, out_valid_a}, {31'h0, exp_a.size() != 0});
            check("a_in_ready", {31'h0, in_ready_a}, {31'h0, exp_a.size() == 0});
            if (out_valid_a && exp_a.size() != 0) begin
                check("a_out_data", out_data_a, exp_a[0].d);
                check("a_out_tap", {28'h0, out_tap_a}, {28'h0, exp_a[0].t});
                check("a_out_last", {31'h0, out_last_a}, {31'h0, exp_a[0].l});
                if (out_ready_a) void'(exp_a.pop_front());
            end
        end
    end

    // Monitor for the TAPS=3 instance
    always @(negedge clk) begin
        if (!rst) begin
            check("b_out_valid", {31'h0, out_valid_b}, {31'h0, exp_b.size() != 0});
            check("b_in_ready", {31'h0, in_ready_b}, {31'h0, exp_b.size() == 0});
            if (out_valid_b && exp_b.size() != 0) begin
                check("b_out_data", out_data_b, exp_b[0].d);
                check("b_out_tap", {28'h0, out_tap_b}, {28'h0, exp_b[0].t});
                check("b_out_last", {31'h0, out_last_b}, {31'h0, exp_b[0].l});
                if (out_ready_b) void'(exp_b.pop_front());
            end
        end
    end

    // Called at posedge+1 while idle; the sample is accepted on the next edge
    task automatic push(input int sel, input logic [31:0] x);
        if (sel == 0) begin
            in_valid_a = 1'b1; in_data_a = x;
        end else begin
            in_valid_b = 1'b1; in_data_b = x;
        end
        @(posedge clk); #1;
        in_valid_a = 1'b0; in_data_a = $urandom;
        in_valid_b = 1'b0; in_data_b = $urandom;
        model_accept(sel, x);
    endtask

    task automatic drain(input int sel, input bit rnd);
        int i;
        i = 0;
        while (((sel == 0) ? exp_a.size() : exp_b.size()) != 0 && i < 200) begin
            if (sel == 0) out_ready_a = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            else          out_ready_b = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(posedge clk); #1;
            i++;
        end
        out_ready_a = 1'b0;
        out_ready_b = 1'b0;
        if (i >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: stream of dut %0d still pending after %0d cycles", sel, i);
            exp_a.delete();
            exp_b.delete();
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge
    task automatic do_reset();
        #2 rst = 1'b1;
        hist_a.delete(); exp_a.delete();
        hist_b.delete(); exp_b.delete();
        #1;
        check("rst_a_in_ready", {31'h0, in_ready_a}, 32'h1);
        check("rst_a_out_valid", {31'h0, out_valid_a}, 32'h0);
        check("rst_a_out_data", out_data_a, 32'h0);
        check("rst_a_out_tap", {28'h0, out_tap_a}, 32'h0);
        check("rst_a_out_last", {31'h0, out_last_a}, 32'h0);
        check("rst_b_in_ready", {31'h0, in_ready_b}, 32'h1);
        check("rst_b_out_valid", {31'h0, out_valid_b}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // First sample into empty history
        push(0, 32'h0000_0011);
        drain(0, 1'b0);

        // Wrap-around with saturating fill
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            push(0, 32'(i));
            drain(0, 1'b1);
        end

        // Backpressure on k=1 with ignored input pulses
        push(0, 32'h0000_00A5);
        out_ready_a = 1'b1;
        @(posedge clk); #1;
        out_ready_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid_a = i[0] ? 1'b0 : 1'b1;
            in_data_a  = 32'h0000_DEAD;
            @(posedge clk); #1;
        end
        in_valid_a = 1'b0;
        drain(0, 1'b0);

        // Reset during k=2 of sample 8
        push(0, 32'h7);
        drain(0, 1'b1);
        push(0, 32'h8);
        out_ready_a = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        out_ready_a = 1'b0;
        do_reset();
        push(0, 32'h9);
        drain(0, 1'b1);

        // Random samples, random gaps and backpressure
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            push(0, $urandom);
            drain(0, 1'b1);
        end

        // Non-power-of-two depth
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            push(1, 32'(i));
            drain(1, 1'b1);
        end
        for (int i = 0; i < 20; i++) begin
            push(1, $urandom);
            drain(1, 1'b1);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
